// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register-address definitions
package mips_pkg;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - per-register pending-write up/down counter
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             saturated,
  output logic             zero
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;

  assign count     = count_q;
  assign saturated = &count_q;
  assign zero      = (count_q == '0);

  // Simultaneous inc and dec cancel; clear wins over both.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && !dec && !saturated)
      count_d = count_q + ONE;
    else if (dec && !inc && !zero)
      count_d = count_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-stage register scoreboard; SCOREBOARD_WB_BYPASS_EN releases sources on same-cycle writeback
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int NUM_REGS    = NUM_ARCH_REGS,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   IssueValid,
  output logic                   IssueReady,
  input  reg_addr_t              IssueRs,
  input  reg_addr_t              IssueRt,
  input  logic                   IssueUseRs,
  input  logic                   IssueUseRt,
  input  reg_addr_t              IssueDst,
  input  logic                   IssueWrites,
  input  logic                   WbValid,
  input  reg_addr_t              WbRegister,
  input  logic                   Flush,
  output logic                   Stall,
  output logic [NUM_REGS-1:0]    BusyMask,
  output logic [STALL_CNT_W-1:0] StallCount,
  output logic                   WbUnderflow
);
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] sat_v, zero_v;
  logic                accept, rs_pending, rt_pending, rs_hazard, rt_hazard, dst_sat;

  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   wb_underflow_q, wb_underflow_d;

  assign cnt[0]    = '0;
  assign sat_v[0]  = 1'b0;
  assign zero_v[0] = 1'b1;

  genvar i;
  generate
    for (i = 1; i < NUM_REGS; i++) begin : g_entry
      sb_entry #(.CNT_W(CNT_W)) u_entry (
        .clk       (Clk),
        .reset     (Reset),
        .inc       (accept && IssueWrites && (IssueDst == reg_addr_t'(i))),
        .dec       (WbValid && (WbRegister == reg_addr_t'(i))),
        .clear     (Flush),
        .count     (cnt[i]),
        .saturated (sat_v[i]),
        .zero      (zero_v[i])
      );
    end
  endgenerate

  always_comb begin
    rs_pending = (cnt[IssueRs] != '0);
    rt_pending = (cnt[IssueRt] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // A source whose last outstanding write retires now reads the written value.
    if (WbValid && (WbRegister == IssueRs) && (cnt[IssueRs] == CNT_W'(1))) rs_pending = 1'b0;
    if (WbValid && (WbRegister == IssueRt) && (cnt[IssueRt] == CNT_W'(1))) rt_pending = 1'b0;
`endif
  end

  assign rs_hazard  = IssueUseRs && (IssueRs != ZERO_REG) && rs_pending;
  assign rt_hazard  = IssueUseRt && (IssueRt != ZERO_REG) && rt_pending;
  assign dst_sat    = IssueWrites && (IssueDst != ZERO_REG) && sat_v[IssueDst];
  assign IssueReady = !Flush && !rs_hazard && !rt_hazard && !dst_sat;
  assign Stall      = IssueValid && !IssueReady;
  assign accept     = IssueValid && IssueReady;
  assign BusyMask   = ~zero_v;

  always_comb begin
    stall_count_d  = stall_count_q;
    wb_underflow_d = wb_underflow_q;
    if (Stall && !(&stall_count_q))
      stall_count_d = stall_count_q + 1'b1;
    if (WbValid && (WbRegister != ZERO_REG) && zero_v[WbRegister])
      wb_underflow_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count_q  <= '0;
      wb_underflow_q <= 1'b0;
    end else begin
      stall_count_q  <= stall_count_d;
      wb_underflow_q <= wb_underflow_d;
    end
  end

  assign StallCount  = stall_count_q;
  assign WbUnderflow = wb_underflow_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed table-driven bench for reg_scoreboard
module tb_reg_scoreboard;
  logic        Clk = 1'b0;
  logic        Reset, IssueValid, IssueUseRs, IssueUseRt, IssueWrites, WbValid, Flush;
  logic [4:0]  IssueRs, IssueRt, IssueDst, WbRegister;
  logic        IssueReady, Stall, WbUnderflow;
  logic [31:0] BusyMask;
  logic [15:0] StallCount;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_scoreboard dut (
    .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .IssueReady(IssueReady),
    .IssueRs(IssueRs), .IssueRt(IssueRt), .IssueUseRs(IssueUseRs), .IssueUseRt(IssueUseRt),
    .IssueDst(IssueDst), .IssueWrites(IssueWrites), .WbValid(WbValid), .WbRegister(WbRegister),
    .Flush(Flush), .Stall(Stall), .BusyMask(BusyMask), .StallCount(StallCount),
    .WbUnderflow(WbUnderflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       wr, wbv;
    logic [4:0] wbr;
    logic       rdy;
    logic [31:0] busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_sc = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] dst,
                              input logic wr, input logic wbv, input logic [4:0] wbr,
                              input logic rdy, input logic [31:0] busy);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.dst = dst;
    t.wr = wr; t.wbv = wbv; t.wbr = wbr; t.rdy = rdy; t.busy = busy;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic wr, input logic wbv, input logic [4:0] wbr, input logic fl);
    IssueValid = v; IssueRs = rs; IssueRt = rt; IssueUseRs = urs; IssueUseRt = urt;
    IssueDst = dst; IssueWrites = wr; WbValid = wbv; WbRegister = wbr; Flush = fl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Main table: RAW stall/release, saturation, same-cycle inc/dec, Rt hazard, zero register.
    vecs.push_back(mk(1, 4, 8, 1, 1, 10, 1, 0, 0, 1, 32'h0000_0400));
    vecs.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0400));
    vecs.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0400));
    vecs.push_back(mk(1, 10, 0, 1, 0, 0, 0, 1, 10, BYP, 32'h0));
    vecs.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 20, 1, 0, 0, 1, 32'h0010_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 32'h0010_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 20, 1, 1, 20, 0, 32'h0010_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 20, 1, 0, 0, 1, 32'h0010_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 32'h0010_0000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 20, 1, 32'h0010_0000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 20, 1, 32'h0010_0000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 20, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 32'h0000_0008));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 3, 1, 32'h0000_0008));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 32'h0000_0040));
    vecs.push_back(mk(1, 0, 6, 0, 1, 0, 0, 0, 0, 0, 32'h0000_0040));
    vecs.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0040));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 32'h0));

    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    Reset = 1'b0;
    check("reset ready", IssueReady, 1);
    check("reset stall", Stall, 0);
    check("reset busy", BusyMask, 0);
    check("reset stallcount", StallCount, 0);
    check("reset underflow", WbUnderflow, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
            vecs[i].dst, vecs[i].wr, vecs[i].wbv, vecs[i].wbr, 0);
      #1;
      check($sformatf("v%0d ready", i), IssueReady, vecs[i].rdy);
      check($sformatf("v%0d stall", i), Stall, vecs[i].v & ~vecs[i].rdy);
      if (vecs[i].v && !vecs[i].rdy) exp_sc++;
      tick();
      check($sformatf("v%0d busy", i), BusyMask, vecs[i].busy);
      check($sformatf("v%0d stallcount", i), StallCount, exp_sc);
    end
    check("table underflow", WbUnderflow, 0);

    // Writeback to register 0 is ignored; to an idle register 25 it is sticky underflow.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check("wb r0 underflow", WbUnderflow, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 25, 0);
    tick();
    check("wb r25 underflow", WbUnderflow, 1);
    check("wb r25 busy", BusyMask, 0);

    // Fill 9/12/15, then flush together with an issue.
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);  tick();
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 15, 1, 0, 0, 0); tick();
    check("fill busy", BusyMask, 32'h0000_9200);
    check("fill underflow sticky", WbUnderflow, 1);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
    #1;
    check("flush ready", IssueReady, 0);
    check("flush stall", Stall, 1);
    exp_sc++;
    tick();
    check("flush busy", BusyMask, 0);
    check("flush stallcount", StallCount, exp_sc);
    check("flush underflow", WbUnderflow, 1);

    // Reset mid-run with a write in flight and an issue presented.
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    check("pre-reset busy", BusyMask, 32'h0000_0080);
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid reset busy", BusyMask, 0);
    check("mid reset stallcount", StallCount, 0);
    check("mid reset underflow", WbUnderflow, 0);
    check("mid reset ready", IssueReady, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
